// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Requester IDs double as bit positions in the two-bit request/grant vectors.
package mips_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick, purely combinational (0 cycles).
// On a tie the requester that was not granted last wins; no backpressure.
module rr_pick2
  import mips_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == REQ_IF) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and datapath; req-to-ack is 2 cycles plus memory waits.
// Backpressure is mem_ready: the owner keeps the bus until it arrives, the other requester just waits.
module mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t     state;
  logic       last;
  logic       arb_en;
  logic [1:0] req_vec;
  logic [1:0] grant;

  // The ack cycle sits in IDLE but must not start a new grant.
  assign arb_en  = (state == IDLE) && !if_ack && !d_ack;
  assign req_vec = {d_req, if_req} & {2{arb_en}};

  rr_pick2 u_pick (
    .req   (req_vec),
    .last  (last),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last     <= REQ_IF;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant[REQ_D])       state <= BUSY_D;
          else if (grant[REQ_IF]) state <= BUSY_IF;
        end
        BUSY_IF: begin
          if (mem_ready) begin
            if_rdata <= mem_rdata;
            if_ack   <= 1'b1;
            last     <= REQ_IF;
            state    <= IDLE;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            d_rdata <= mem_rdata;
            d_ack   <= 1'b1;
            last    <= REQ_D;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      BUSY_IF: begin
        mem_req  = 1'b1;
        mem_addr = if_addr;
      end
      BUSY_D: begin
        mem_req   = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a word memory with programmable wait states plus a
// transaction-level reference memory that predicts every load result.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] ref_mem [0:255];
  logic [31:0] env_mem [0:255];
  logic        load_env;
  int          mem_wait;
  int          busy_cnt;
  logic        spurious_ready;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory side: ready after mem_wait stalled cycles, writes on the ready edge.
  assign mem_ready = spurious_ready | (mem_req && (busy_cnt == mem_wait));
  assign mem_rdata = env_mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (load_env)
      for (int i = 0; i < 256; i++) env_mem[i] <= ref_mem[i];
    else if (mem_req && mem_ready && mem_we)
      env_mem[mem_addr[9:2]] <= mem_wdata;
    if (reset || !mem_req || mem_ready) busy_cnt <= 0;
    else                                busy_cnt <= busy_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input logic port, input logic v);
    if (port) d_req = v;
    else      if_req = v;
  endtask

  // Runs one transaction from an idle arbiter and reports what it observed.
  task automatic do_txn(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waitc, input bit drop,
                        output int lat, output int acks, output logic [31:0] rdata,
                        output int stalls, output bit route_err, output bit both_err,
                        output bit other_held);
    logic [31:0] other0;
    logic        own;
    logic        oth;
    lat = -1; acks = 0; rdata = '0; stalls = 0;
    route_err = 0; both_err = 0; other_held = 1;
    mem_wait = waitc;
    other0 = port ? if_rdata : d_rdata;
    if (port) begin
      d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_addr = addr;
    end
    set_req(port, 1'b1);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (drop && c == 1) set_req(port, 1'b0);
      if (mem_req) begin
        if (mem_addr !== addr || mem_we !== (port ? we : 1'b0) ||
            (port && we && mem_wdata !== wdata)) route_err = 1;
        if (!mem_ready) stalls++;
      end else if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
        route_err = 1;
      end
      own = port ? d_ack : if_ack;
      oth = port ? if_ack : d_ack;
      if (if_ack && d_ack) both_err = 1;
      if (oth !== 1'b0 || (port ? if_rdata : d_rdata) !== other0) other_held = 0;
      if (own === 1'b1) begin
        acks++;
        if (lat < 0) begin
          lat = c;
          rdata = port ? d_rdata : if_rdata;
          set_req(port, 1'b0);
        end
      end
      if (lat >= 0 && c >= lat + 3) break;
    end
    set_req(port, 1'b0);
    mem_wait = 0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    load_env = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    load_env = 1'b0;
    reset = 1'b0;
    tests_run++;
    if ({if_ack, d_ack, mem_req, mem_we} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b required 0000 (if_ack,d_ack,mem_req,mem_we)",
               {if_ack, d_ack, mem_req, mem_we});
    end
    tests_run++;
    if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rdata: got if=%h d=%h required 0", if_rdata, d_rdata);
    end
    tests_run++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: got addr=%h wdata=%h required 0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_single_fetch;
    int lat, acks, stalls; logic [31:0] rd; bit re, be, oh;
    do_txn(1'b0, 1'b0, 32'h40, 32'h0, 0, 0, lat, acks, rd, stalls, re, be, oh);
    tests_run++;
    if (lat != 2) begin tests_failed++; $display("FAIL fetch_latency: got %0d required 2", lat); end
    tests_run++;
    if (acks != 1) begin tests_failed++; $display("FAIL fetch_ack_count: got %0d required 1", acks); end
    tests_run++;
    if (rd !== 32'h2008FEFE) begin tests_failed++; $display("FAIL fetch_data: got %h required 2008fefe", rd); end
    tests_run++;
    if (re || be) begin tests_failed++; $display("FAIL fetch_bus: got route_err=%0d both_ack=%0d required 0", re, be); end
  endtask

  task automatic test_store_load;
    int lat, acks, stalls; logic [31:0] rd; bit re, be, oh;
    do_txn(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 0, 0, lat, acks, rd, stalls, re, be, oh);
    ref_mem[8'h40] = 32'hDEADBEEF;
    tests_run++;
    if (acks != 1 || lat != 2 || re) begin
      tests_failed++;
      $display("FAIL store: got acks=%0d lat=%0d route_err=%0d required 1/2/0", acks, lat, re);
    end
    do_txn(1'b1, 1'b0, 32'h100, 32'h0, 0, 0, lat, acks, rd, stalls, re, be, oh);
    tests_run++;
    if (acks != 1 || rd !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL load_after_store: got acks=%0d data=%h required 1/deadbeef", acks, rd);
    end
  endtask

  task automatic test_wait_states;
    int lat, acks, stalls; logic [31:0] rd; bit re, be, oh;
    do_txn(1'b0, 1'b0, 32'h24, 32'h0, 3, 0, lat, acks, rd, stalls, re, be, oh);
    tests_run++;
    if (stalls != 3 || re) begin
      tests_failed++;
      $display("FAIL wait_stall: got stalls=%0d route_err=%0d required 3/0", stalls, re);
    end
    tests_run++;
    if (lat != 5 || acks != 1 || rd !== ref_mem[9]) begin
      tests_failed++;
      $display("FAIL wait_ack: got lat=%0d acks=%0d data=%h required 5/1/%h", lat, acks, rd, ref_mem[9]);
    end
  endtask

  task automatic test_dropped_req;
    int lat, acks, stalls; logic [31:0] rd; bit re, be, oh;
    do_txn(1'b1, 1'b0, 32'h30, 32'h0, 2, 1, lat, acks, rd, stalls, re, be, oh);
    tests_run++;
    if (acks != 1 || lat != 4 || rd !== ref_mem[12]) begin
      tests_failed++;
      $display("FAIL dropped_req: got acks=%0d lat=%0d data=%h required 1/4/%h", acks, lat, rd, ref_mem[12]);
    end
  endtask

  task automatic test_idle_ready;
    int acks;
    acks = 0;
    spurious_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (if_ack || d_ack || mem_req) acks++;
    end
    spurious_ready = 1'b0;
    tests_run++;
    if (acks != 0) begin tests_failed++; $display("FAIL idle_ready: got %0d active cycles required 0", acks); end
  endtask

  task automatic test_reset_midop;
    int acks;
    acks = 0;
    mem_wait = 20;
    d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h12345678;
    d_req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    tests_run++;
    if (mem_req !== 1'b1) begin tests_failed++; $display("FAIL midop_busy: got mem_req=%b required 1", mem_req); end
    reset = 1'b1;
    d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || d_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL midop_reset: got mem_req=%b addr=%h d_ack=%b required 0/0/0", mem_req, mem_addr, d_ack);
    end
    tests_run++;
    if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL midop_rdata: got if=%h d=%h required 0", if_rdata, d_rdata);
    end
    repeat (6) begin
      @(posedge clk); #1;
      if (d_ack || mem_req) acks++;
    end
    tests_run++;
    if (acks != 0) begin tests_failed++; $display("FAIL midop_no_ack: got %0d active cycles required 0", acks); end
    mem_wait = 0;
  endtask

  task automatic test_contention;
    int order [$];
    int both;
    int bad;
    both = 0;
    bad = 0;
    reset = 1'b1;
    if_addr = 32'h10; d_addr = 32'h20; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (if_ack && d_ack) both++;
      if (if_ack) begin order.push_back(0); if (if_rdata !== ref_mem[4]) bad++; end
      if (d_ack)  begin order.push_back(1); if (d_rdata !== ref_mem[8]) bad++; end
    end
    if_req = 1'b0; d_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (both != 0) begin tests_failed++; $display("FAIL contention_both_ack: got %0d cycles required 0", both); end
    tests_run++;
    if (order.size() < 4) begin
      tests_failed++;
      $display("FAIL contention_count: got %0d acks required at least 4", order.size());
    end
    for (int k = 0; k < order.size(); k++) begin
      tests_run++;
      if (order[k] != ((k % 2 == 0) ? 1 : 0)) begin
        tests_failed++;
        $display("FAIL contention_order[%0d]: got %0d required %0d (1=D,0=IF)", k, order[k], (k % 2 == 0) ? 1 : 0);
      end
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL contention_data: got %0d bad words required 0", bad); end
  endtask

  task automatic test_random;
    int lat, acks, stalls, waitc, idx; logic [31:0] rd, addr, wdata; bit re, be, oh;
    logic port, we;
    for (int n = 0; n < 24; n++) begin
      port  = 1'($urandom_range(0, 1));
      we    = port ? 1'($urandom_range(0, 1)) : 1'b0;
      idx   = $urandom_range(0, 15);
      addr  = 32'(idx) << 2;
      wdata = $urandom;
      waitc = $urandom_range(0, 3);
      do_txn(port, we, addr, wdata, waitc, 0, lat, acks, rd, stalls, re, be, oh);
      tests_run++;
      if (acks != 1 || lat != 2 + waitc || stalls != waitc) begin
        tests_failed++;
        $display("FAIL rand[%0d]_timing: got acks=%0d lat=%0d stalls=%0d required 1/%0d/%0d",
                 n, acks, lat, stalls, 2 + waitc, waitc);
      end
      tests_run++;
      if (re || be || !oh) begin
        tests_failed++;
        $display("FAIL rand[%0d]_bus: got route_err=%0d both_ack=%0d other_held=%0d required 0/0/1", n, re, be, oh);
      end
      if (we) begin
        ref_mem[idx] = wdata;
      end else begin
        tests_run++;
        if (rd !== ref_mem[idx]) begin
          tests_failed++;
          $display("FAIL rand[%0d]_data: got %h required %h", n, rd, ref_mem[idx]);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_wait = 0;
    spurious_ready = 1'b0;
    load_env = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[16] = 32'h2008FEFE;

    test_reset;
    test_single_fetch;
    test_store_load;
    test_wait_states;
    test_dropped_req;
    test_idle_ready;
    test_reset_midop;
    test_contention;
    test_random;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
